// File: rtl/mm_result_ctrl.sv
// Display-mode controller for the multimeter result stage: button edges drive source select,
// clear pulses and the hold gate; a per-source timeout flags a stale display.
module mm_result_ctrl #(
  parameter int CLR_CYCLES  = 2,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn_i,
  input  logic       hold_btn_i,
  input  logic       clr_btn_i,
  input  logic       upd_val_i,
  input  logic       upd_fir_i,
  input  logic       upd_rms_i,
  input  logic       upd_iir_i,
  output logic [1:0] din_sel_o,
  output logic       clr_o,
  output logic       upd_en_o,
  output logic       hold_o,
  output logic       stale_o,
  output logic [1:0] state_o
);

  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_CLEAR = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t        r_state;
  logic [1:0]    r_din_sel;
  logic [CW-1:0] r_clr_cnt;
  logic [TW-1:0] r_to_cnt;
  logic          r_stale;
  logic          r_mode_prev;
  logic          r_hold_prev;
  logic          r_clr_prev;

  logic w_mode_edge;
  logic w_hold_edge;
  logic w_clr_edge;
  logic w_sel_upd;
  logic w_to_hit;

  // prev registers reset high so a button held through reset yields no edge
  assign w_mode_edge = mode_btn_i & ~r_mode_prev;
  assign w_hold_edge = hold_btn_i & ~r_hold_prev;
  assign w_clr_edge  = clr_btn_i  & ~r_clr_prev;
  assign w_to_hit    = (r_to_cnt == TO_LAST) & ~w_sel_upd;

  always_comb begin
    w_sel_upd = 1'b0;
    case (r_din_sel)
      2'b00:   w_sel_upd = upd_val_i;
      2'b01:   w_sel_upd = upd_fir_i;
      2'b10:   w_sel_upd = upd_rms_i;
      default: w_sel_upd = upd_iir_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_din_sel   <= 2'b00;
      r_clr_cnt   <= '0;
      r_to_cnt    <= '0;
      r_stale     <= 1'b0;
      r_mode_prev <= 1'b1;
      r_hold_prev <= 1'b1;
      r_clr_prev  <= 1'b1;
    end else begin
      r_mode_prev <= mode_btn_i;
      r_hold_prev <= hold_btn_i;
      r_clr_prev  <= clr_btn_i;

      // timeout runs in RUN/WAIT, is cleared in CLEAR and frozen in HOLD
      if (r_state == ST_RUN || r_state == ST_WAIT) begin
        if (w_sel_upd) begin
          r_to_cnt <= '0;
          r_stale  <= 1'b0;
        end else if (r_to_cnt == TO_LAST) begin
          r_stale  <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else if (r_state == ST_CLEAR) begin
        r_to_cnt <= '0;
        r_stale  <= 1'b0;
      end

      case (r_state)
        ST_RUN, ST_HOLD: begin
          if (w_mode_edge) begin
            r_din_sel <= r_din_sel + 2'd1;
            r_clr_cnt <= '0;
            r_state   <= ST_CLEAR;
          end else if (w_clr_edge) begin
            r_clr_cnt <= '0;
            r_state   <= ST_CLEAR;
          end else if (w_hold_edge) begin
            r_state   <= (r_state == ST_RUN) ? ST_HOLD : ST_RUN;
          end
        end
        ST_CLEAR: begin
          if (r_clr_cnt == CLR_LAST) begin
            r_state <= ST_WAIT;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: begin
          if (w_mode_edge) begin
            r_din_sel <= r_din_sel + 2'd1;
            r_clr_cnt <= '0;
            r_state   <= ST_CLEAR;
          end else if (w_clr_edge) begin
            r_clr_cnt <= '0;
            r_state   <= ST_CLEAR;
          end else if (w_sel_upd || w_to_hit) begin
            r_state   <= ST_RUN;
          end
        end
      endcase
    end
  end

  assign din_sel_o = r_din_sel;
  assign clr_o     = (r_state == ST_CLEAR);
  assign upd_en_o  = (r_state == ST_RUN) || (r_state == ST_WAIT);
  assign hold_o    = (r_state == ST_HOLD);
  assign stale_o   = r_stale;
  assign state_o   = r_state;

endmodule
